// File: rtl/ex_hazard_sequencer.sv
// EX-stage hazard sequencer: load-use stalls, multi-cycle multiply occupancy,
// and branch-taken flushes for a five-stage pipeline.
module ex_hazard_sequencer #(
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_dest,
    input  logic        ex_mult_valid,
    input  logic        mem_branch,
    input  logic        mem_zero,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        mult_busy,
    output logic        mult_done,
    output logic [15:0] stall_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    // The entry cycle is spent in RUN and the final count cycle in MULT, hence -2.
    localparam logic [3:0] CNT_LOAD = 4'(MULT_LATENCY - 2);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_next_s;
    logic        branch_taken_s;
    logic        load_use_s;

    assign branch_taken_s = mem_branch & mem_zero;
    assign load_use_s     = ex_MemRead & (ex_dest != 5'd0) &
                            ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
    assign state          = state_r;

    // Next-state and hazard-control decode; branch resolution outranks everything.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        mult_busy     = 1'b0;
        mult_done     = 1'b0;
        state_next_s  = state_r;
        cnt_next_s    = 4'd0;
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
            state_next_s  = RUN;
        end else if (branch_taken_s) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_next_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_mult_valid) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        mult_busy     = 1'b1;
                        state_next_s  = MULT;
                        cnt_next_s    = CNT_LOAD;
                    end else if (load_use_s) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                MULT: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    mult_busy     = 1'b1;
                    if (cnt_r == 4'd0) begin
                        state_next_s = DONE;
                    end else begin
                        cnt_next_s = cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    mult_done = 1'b1;
                    if (load_use_s) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                    // Back-to-back multiply re-enters MULT straight from DONE.
                    if (ex_mult_valid) begin
                        state_next_s = MULT;
                        cnt_next_s   = CNT_LOAD;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    id_ex_bubble  = 1'b1;
                    ex_mem_bubble = 1'b1;
                    state_next_s  = RUN;
                end
            endcase
        end
    end

    // State and multiply-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end else begin
            stall_count <= stall_count;
        end
    end

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Directed bench for ex_hazard_sequencer: single-cycle hazard vector table
// plus hand-written multiply, branch-abort, reset-abort and saturation sequences.
module tb_ex_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_dest;
    logic        id_uses_rt, ex_MemRead, ex_mult_valid, mem_branch, mem_zero;
    logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, mult_busy, mult_done;
    logic [15:0] stall_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    ex_hazard_sequencer #(.MULT_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_dest(ex_dest), .ex_mult_valid(ex_mult_valid),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .mult_busy(mult_busy), .mult_done(mult_done),
        .stall_count(stall_count), .state(state)
    );

    typedef struct {
        logic [4:0] rs, rt, dest;
        logic       uses_rt, memread, branch, zero;
        logic       e_pc, e_bubble, e_flush;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0; id_uses_rt = 1'b0;
        ex_MemRead = 1'b0; ex_mult_valid = 1'b0; mem_branch = 1'b0; mem_zero = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic start_mult();
        idle();
        ex_mult_valid = 1'b1;
        #1;
        check("mult_entry_busy", {31'd0, mult_busy}, 32'd1);
        check("mult_entry_pc", {31'd0, pc_write}, 32'd0);
        check("mult_entry_exmem_bubble", {31'd0, ex_mem_bubble}, 32'd1);
        next_cycle();
        ex_mult_valid = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd8,  5'd0, 5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{5'd3,  5'd5, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd5,  5'd0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{5'd9,  5'd0, 5'd9,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{5'd31, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset behaviour with hostile inputs.
        idle();
        rst = 1'b1;
        ex_MemRead = 1'b1; ex_dest = 5'd8; id_rs = 5'd8; mem_branch = 1'b1; mem_zero = 1'b1;
        ex_mult_valid = 1'b1;
        next_cycle();
        next_cycle();
        check("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_id_ex_write", {31'd0, id_ex_write}, 32'd0);
        check("rst_flushes", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'd7);
        check("rst_bubbles", {30'd0, id_ex_bubble, ex_mem_bubble}, 32'd3);
        check("rst_mult", {30'd0, mult_busy, mult_done}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_stall_count", {16'd0, stall_count}, 32'd0);
        idle();
        rst = 1'b0;
        next_cycle();

        // Single-cycle hazard table, all from RUN.
        exp_stall = 0;
        for (int i = 0; i < 10; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_dest = vecs[i].dest;
            id_uses_rt = vecs[i].uses_rt; ex_MemRead = vecs[i].memread;
            mem_branch = vecs[i].branch; mem_zero = vecs[i].zero; ex_mult_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].e_pc});
            check($sformatf("vec%0d_if_id_write", i), {31'd0, if_id_write}, {31'd0, vecs[i].e_pc});
            check($sformatf("vec%0d_id_ex_write", i), {31'd0, id_ex_write}, 32'd1);
            check($sformatf("vec%0d_id_ex_bubble", i), {31'd0, id_ex_bubble}, {31'd0, vecs[i].e_bubble});
            check($sformatf("vec%0d_flushes", i), {29'd0, flush_if_id, flush_id_ex, flush_ex_mem},
                  vecs[i].e_flush ? 32'd7 : 32'd0);
            check($sformatf("vec%0d_mult", i), {29'd0, ex_mem_bubble, mult_busy, mult_done}, 32'd0);
            if (!vecs[i].e_pc) exp_stall++;
            next_cycle();
            check($sformatf("vec%0d_state", i), {30'd0, state}, 32'd0);
            check($sformatf("vec%0d_stall_count", i), {16'd0, stall_count}, exp_stall);
        end

        // Single load-use stall: one cycle only, counter +1.
        do_reset();
        ex_MemRead = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
        #1;
        check("lu_pc_write", {31'd0, pc_write}, 32'd0);
        check("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        next_cycle();
        idle();
        #1;
        check("lu_after_pc_write", {31'd0, pc_write}, 32'd1);
        check("lu_after_bubble", {31'd0, id_ex_bubble}, 32'd0);
        check("lu_stall_count", {16'd0, stall_count}, 32'd1);

        // Full multiply, MULT_LATENCY=4.
        do_reset();
        start_mult();
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("mul_c%0d_state", c), {30'd0, state}, 32'd1);
            check($sformatf("mul_c%0d_busy", c), {31'd0, mult_busy}, 32'd1);
            check($sformatf("mul_c%0d_pc", c), {31'd0, pc_write}, 32'd0);
            check($sformatf("mul_c%0d_done", c), {31'd0, mult_done}, 32'd0);
            next_cycle();
        end
        check("mul_c4_state", {30'd0, state}, 32'd2);
        check("mul_c4_done", {31'd0, mult_done}, 32'd1);
        check("mul_c4_busy", {31'd0, mult_busy}, 32'd0);
        check("mul_c4_pc", {31'd0, pc_write}, 32'd1);
        next_cycle();
        check("mul_c5_state", {30'd0, state}, 32'd0);
        check("mul_c5_done", {31'd0, mult_done}, 32'd0);
        check("mul_stall_count", {16'd0, stall_count}, 32'd4);

        // Load-use arriving in DONE still stalls, with mult_done asserted.
        do_reset();
        start_mult();
        next_cycle();
        next_cycle();
        next_cycle();
        ex_MemRead = 1'b1; ex_dest = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
        #1;
        check("done_lu_done", {31'd0, mult_done}, 32'd1);
        check("done_lu_pc", {31'd0, pc_write}, 32'd0);
        check("done_lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        next_cycle();
        idle();
        #1;
        check("done_lu_state", {30'd0, state}, 32'd0);
        check("done_lu_stall_count", {16'd0, stall_count}, 32'd5);

        // Branch taken in cycle 2 of a multiply aborts it.
        do_reset();
        start_mult();
        next_cycle();
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1;
        check("br_mul_flushes", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'd7);
        check("br_mul_pc", {31'd0, pc_write}, 32'd1);
        check("br_mul_bubbles", {30'd0, id_ex_bubble, ex_mem_bubble}, 32'd0);
        next_cycle();
        idle();
        #1;
        check("br_mul_state", {30'd0, state}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("br_mul_nodone%0d", c), {31'd0, mult_done}, 32'd0);
            next_cycle();
        end
        check("br_mul_state_end", {30'd0, state}, 32'd0);

        // Reset in the middle of a multiply aborts without mult_done.
        do_reset();
        start_mult();
        next_cycle();
        rst = 1'b1;
        #1;
        check("rst_mul_busy", {30'd0, mult_busy, mult_done}, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_mul_nodone%0d", c), {31'd0, mult_done}, 32'd0);
            check($sformatf("rst_mul_state%0d", c), {30'd0, state}, 32'd0);
            next_cycle();
        end

        // Saturation of the stall counter.
        do_reset();
        ex_MemRead = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
        repeat (65540) @(negedge clk);
        #1;
        check("sat_stall_count", {16'd0, stall_count}, 32'h0000FFFF);
        next_cycle();
        check("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
        idle();
        do_reset();
        check("sat_reset", {16'd0, stall_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_hazard_sequencer.md
EX_HAZARD_SEQUENCER -- requirements
Module: ex_hazard_sequencer

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 4, EX-stage occupancy in cycles of a multiply (legal 2..16).
REQ-002 SHALL have ports:
  clk  input  1  rising-edge clock.
  rst  input  1  synchronous active-high reset.
  id_rs  input  5  rs field of the instruction in ID.
  id_rt  input  5  rt field of the instruction in ID.
  id_uses_rt  input  1  ID instruction reads rt.
  ex_MemRead  input  1  EX instruction is a load.
  ex_dest  input  5  EX writeback destination.
  ex_mult_valid  input  1  EX instruction is a multiply.
  mem_branch  input  1  MEM instruction is a branch.
  mem_zero  input  1  MEM zero flag.
  pc_write  output  1  PC update enable.
  if_id_write  output  1  IF/ID register enable.
  id_ex_write  output  1  ID/EX register enable.
  id_ex_bubble  output  1  load zeroed controls into ID/EX.
  ex_mem_bubble  output  1  load zeroed controls into EX/MEM.
  flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  clear the named pipeline register.
  mult_busy  output  1  multiply occupying EX.
  mult_done  output  1  one-cycle multiply completion pulse.
  stall_count  output  16  stalled-cycle counter.
  state  output  2  RUN=0, MULT=1, DONE=2.

Function
REQ-003 SHALL implement states RUN, MULT, DONE; hazard/flush outputs are combinational from state and current inputs.
REQ-004 branch_taken = mem_branch & mem_zero; SHALL take priority over every other condition in every state.
REQ-005 On branch_taken: flush_if_id=flush_id_ex=flush_ex_mem=1, pc_write=if_id_write=id_ex_write=1, no bubbles, next state RUN, multiply counter cleared, no mult_done.
REQ-006 load_use = ex_MemRead & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
REQ-007 In RUN or DONE with load_use and no branch_taken: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1; state unchanged; exactly the cycles load_use is true are stalled.
REQ-008 ex_dest==0 SHALL never cause a stall.
REQ-009 In RUN with ex_mult_valid and no branch_taken: go to MULT, counter loaded with MULT_LATENCY-2; ex_mult_valid SHALL override ex_MemRead if both asserted.
REQ-010 In MULT and in the RUN cycle of entry: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, mult_busy=1.
REQ-011 In MULT: counter decrements each cycle; at counter==0 next state DONE.
REQ-012 DONE lasts exactly one cycle: mult_done=1, mult_busy=0, all write enables 1 unless REQ-007 applies, next state RUN (or MULT if ex_mult_valid again).
REQ-013 Multiply total stall is MULT_LATENCY cycles from the entry cycle; mult_done in cycle MULT_LATENCY after entry.
REQ-014 In RUN with no condition: pc_write=if_id_write=id_ex_write=1, all bubbles and flushes 0.
REQ-015 stall_count SHALL increment on every clock where pc_write=0 and rst=0; saturates at 0xFFFF, no wrap.
REQ-016 Unused counter bits SHALL be 0; state value 3 SHALL recover to RUN next cycle.

Reset
REQ-017 With rst high at a clock edge: state=RUN, counter=0, stall_count=0.
REQ-018 While rst high: pc_write=if_id_write=id_ex_write=0, all bubble and flush outputs 1, mult_busy=mult_done=0, regardless of inputs.
REQ-019 rst asserted mid-multiply SHALL abort it without mult_done.

Verification
REQ-020 ex_MemRead=1, ex_dest=8, id_rs=8, one cycle -> pc_write=0, id_ex_bubble=1 that cycle only; stall_count=1.
REQ-021 ex_MemRead=1, ex_dest=0, id_rs=0 -> no stall, pc_write=1.
REQ-022 ex_mult_valid=1, MULT_LATENCY=4 -> mult_busy=1 cycles 0..3, state MULT cycles 1..3, mult_done=1 cycle 4, stall_count=4.
REQ-023 Multiply started, mem_branch=mem_zero=1 in cycle 2 -> all three flushes 1, state RUN next cycle, no mult_done.
REQ-024 load_use and branch_taken same cycle -> flushes 1, pc_write=1, no bubble.
REQ-025 Force 65540 stalled cycles -> stall_count holds 0xFFFF; rst -> 0.
